alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU, for the pipelined core's execute stage. Accepts one operation per transfer on a valid/ready input channel and returns a registered result on a valid/ready output channel. All single-cycle ops complete in one cycle. MUL adds an iterative shift-add multiplier that holds the unit busy for WIDTH cycles.

## Interface
- WIDTH, 16: datapath width; must be even and at least 8.
- SHW, $clog2(WIDTH): width of the shift/rotate amount.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready at a rising edge.
- op  in  4  opcode, encoding below.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result word.
- cout, ofl  out  1  carry-out and signed overflow of ADD/SUB; 0 for all other ops.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 XOR.
  - 3 ANDN: a&~b.
  - 4 ROL, 5 SLL, 6 ROR, 7 SRL: a shifted or rotated by b[SHW-1:0].
  - 8 BTR: bit-reverse a.
  - 9 SEQ, 10 SLT, 11 SLE: signed compare of a against b; result is {0…,flag}.
  - 12 SCO: {0…,carry of a+b}.
  - 13 LBI: b.
  - 14 SLBI: (a<<WIDTH/2)|b[WIDTH/2-1:0].
  - 15 MUL: low WIDTH bits of a*b, unsigned.
- Signed compares must be overflow-correct. Example: a=0x8000, b=0x7FFF gives SLT=1.
- All adds are WIDTH bits. cout is the bit-WIDTH carry. For SUB, cout is the carry of a+~b+1.
- FSM states:
  - IDLE: accepts operations.
    - Accepting a non-MUL op writes result/cout/ofl and sets out_valid; state stays IDLE.
    - Accepting MUL latches a into mcand and b into mplier, clears the accumulator and counter cnt, and moves to MUL.
  - MUL: each cycle, if mplier[0] then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
    - When cnt == WIDTH-1, write acc (including this cycle's add) to result, set out_valid, clear cout/ofl, return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Pass-through is allowed: a new op is accepted in the same cycle the old result is taken.
- out_valid falls on out_valid && out_ready unless a new result is written in that same cycle. result stays stable while out_valid && !out_ready.
- Reset (rst_n=0 at an edge):
  - out_valid=0, result=0, cout=0, ofl=0.
  - state=IDLE, cnt=0, accumulator cleared.
  - Mid-MUL reset abandons the operation; no result is produced.

## Timing
- Non-MUL: accepted at edge N, out_valid=1 after edge N. Latency is 1 cycle, throughput 1 per cycle with out_ready held high.
- MUL: accepted at edge N; in_ready=0 after edges N…N+WIDTH-1; out_valid=1 after edge N+WIDTH. in_ready returns after edge N+WIDTH, gated by the output handshake rule.
- Output register is guaranteed free when MUL completes, because acceptance required that condition and nothing else is written in the meantime.
- in_valid during MUL is ignored. The producer must hold op, a and b until accepted.

## Structure
- Package alu_seq_pkg holds:
  - the opcode enum alu_op_e (16 values above);
  - FSM enum alu_state_e {IDLE, MUL};
  - helper function for overflow-correct signed compare.
- Sub-module alu_seq_comb: purely combinational single-cycle function of (op, a, b) returning result/cout/ofl, parametrised on WIDTH.
- alu_seq owns the handshake, FSM, multiplier registers and output register.

## Test plan
- Reset: assert rst_n=0 during a MUL, release -> out_valid=0, result=0, in_ready=1, and no stale MUL result appears.
- ADD 0x7FFF+0x0001 -> result 0x8000, ofl=1, cout=0. SUB 0x0000-0x0001 -> 0xFFFF, cout=0.
- SLT a=0x8000, b=0x7FFF -> 0x0001. SLE a=b=0x1234 -> 0x0001. ROR 0x0001 by 1 -> 0x8000. SLBI a=0x00AB, b=0x00CD -> 0xABCD. BTR 0x0001 -> 0x8000.
- MUL 0x0123*0x0011 -> 0x1353 exactly 16 cycles after acceptance, with in_ready low for those 16 cycles. MUL 0xFFFF*0xFFFF -> 0x0001.
- Back-pressure: hold out_ready=0 after an ADD -> result stable, in_ready=0. Raise out_ready with a new op valid -> same-edge handoff, with no bubble and no lost or duplicated result.
- Randomised stream of 1000 ops at WIDTH=16 and WIDTH=32, with random valid/ready, compared against a reference model -> results match and arrive in order.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the sequential ALU: opcode and FSM
// encodings plus the overflow-correct signed-compare helper.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_XOR  = 4'd2,
      OP_ANDN = 4'd3,
      OP_ROL  = 4'd4,
      OP_SLL  = 4'd5,
      OP_ROR  = 4'd6,
      OP_SRL  = 4'd7,
      OP_BTR  = 4'd8,
      OP_SEQ  = 4'd9,
      OP_SLT  = 4'd10,
      OP_SLE  = 4'd11,
      OP_SCO  = 4'd12,
      OP_LBI  = 4'd13,
      OP_SLBI = 4'd14,
      OP_MUL  = 4'd15
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

   // Signed a < b from the sign bits and the msb of a-b. When the signs
   // differ the subtraction may overflow, so the sign of a decides;
   // otherwise the difference cannot overflow and its sign is exact.
   function automatic logic signed_lt(input logic a_msb,
                                      input logic b_msb,
                                      input logic diff_msb);
      return (a_msb != b_msb) ? a_msb : diff_msb;
   endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU function of (op, a, b). MUL is handled by the
// iterative multiplier in the parent, so it yields zeros here.
module alu_seq_comb
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ofl
);

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_sum;
   logic [SHW-1:0]     sh;
   logic [2*WIDTH-1:0] rol_full;
   logic [2*WIDTH-1:0] ror_full;
   logic [WIDTH-1:0]   btr;
   logic               add_ofl;
   logic               sub_ofl;
   logic               lt_flag;
   logic               eq_flag;

   // Subtraction is a + ~b + 1 so its carry is the "no borrow" flag.
   assign add_sum = {1'b0, a} + {1'b0, b};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   // Rotates come from shifting a doubled copy of a: the half that
   // survives already has the wrapped-around bits in place.
   assign sh       = b[SHW-1:0];
   assign rol_full = {a, a} << sh;
   assign ror_full = {a, a} >> sh;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_btr
         assign btr[gi] = a[WIDTH-1-gi];
      end
   endgenerate

   assign add_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ofl = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
   assign lt_flag = signed_lt(a[WIDTH-1], b[WIDTH-1], sub_sum[WIDTH-1]);
   assign eq_flag = (a == b);

   // Opcode decode; flags only come from ADD/SUB.
   always_comb begin
      result = '0;
      cout   = 1'b0;
      ofl    = 1'b0;
      case (op)
         OP_ADD: begin
            result = add_sum[WIDTH-1:0];
            cout   = add_sum[WIDTH];
            ofl    = add_ofl;
         end
         OP_SUB: begin
            result = sub_sum[WIDTH-1:0];
            cout   = sub_sum[WIDTH];
            ofl    = sub_ofl;
         end
         OP_XOR:  result = a ^ b;
         OP_ANDN: result = a & ~b;
         OP_ROL:  result = rol_full[2*WIDTH-1:WIDTH];
         OP_SLL:  result = a << sh;
         OP_ROR:  result = ror_full[WIDTH-1:0];
         OP_SRL:  result = a >> sh;
         OP_BTR:  result = btr;
         OP_SEQ:  result = {{(WIDTH-1){1'b0}}, eq_flag};
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_flag};
         OP_SLE:  result = {{(WIDTH-1){1'b0}}, lt_flag | eq_flag};
         OP_SCO:  result = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
         OP_LBI:  result = b;
         OP_SLBI: result = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU for the execute stage: single-cycle ops through
// alu_seq_comb, MUL through a WIDTH-cycle shift-add multiplier, and a
// registered valid/ready output stage.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ofl
);

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   alu_op_e          op_e;
   logic [WIDTH-1:0] comb_result;
   logic             comb_cout;
   logic             comb_ofl;
   logic             accept;
   logic [WIDTH-1:0] acc_sum;

   alu_state_e       state_q,     state_d;
   logic [WIDTH-1:0] mcand_q,     mcand_d;
   logic [WIDTH-1:0] mplier_q,    mplier_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic [SHW-1:0]   cnt_q,       cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             cout_q,      cout_d;
   logic             ofl_q,       ofl_d;

   assign op_e = alu_op_e'(op);

   alu_seq_comb #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_comb (
      .op     (op_e),
      .a      (a),
      .b      (b),
      .result (comb_result),
      .cout   (comb_cout),
      .ofl    (comb_ofl)
   );

   // Output register may be refilled in the same cycle it is drained.
   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign ofl       = ofl_q;

   // Next-state: handshake, op dispatch and one multiplier step per cycle.
   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      cout_d      = cout_q;
      ofl_d       = ofl_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op_e == OP_MUL) begin
                  mcand_d  = a;
                  mplier_d = b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = MUL;
               end else begin
                  result_d    = comb_result;
                  cout_d      = comb_cout;
                  ofl_d       = comb_ofl;
                  out_valid_d = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == CNT_LAST) begin
               result_d    = acc_sum;
               cout_d      = 1'b0;
               ofl_d       = 1'b0;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         ofl_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         ofl_q       <= ofl_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed checks on a 16-bit instance and random
// handshaked streams on 16- and 32-bit instances against a reference model.
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid_w  [2];
   logic [3:0]  op_w        [2];
   logic [31:0] a_w         [2];
   logic [31:0] b_w         [2];
   logic        out_ready_w [2];

   logic        ir16, ov16, cout16, ofl16;
   logic [15:0] res16;
   logic        ir32, ov32, cout32, ofl32;
   logic [31:0] res32;

   int tests = 0;
   int fails = 0;

   typedef struct {
      longint unsigned r;
      bit              c;
      bit              o;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic        o;
   } vec_t;

   vec_t vecs [7] = '{
      '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1},   // ADD
      '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0},   // SUB
      '{4'd10, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0},   // SLT
      '{4'd11, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0},   // SLE
      '{4'd6,  16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0},   // ROR
      '{4'd14, 16'h00AB, 16'h00CD, 16'hABCD, 1'b0, 1'b0},   // SLBI
      '{4'd8,  16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0}    // BTR
   };

   alu_seq #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_w[0]),
      .in_ready  (ir16),
      .op        (op_w[0]),
      .a         (a_w[0][15:0]),
      .b         (b_w[0][15:0]),
      .out_valid (ov16),
      .out_ready (out_ready_w[0]),
      .result    (res16),
      .cout      (cout16),
      .ofl       (ofl16)
   );

   alu_seq #(.WIDTH(32)) dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_w[1]),
      .in_ready  (ir32),
      .op        (op_w[1]),
      .a         (a_w[1]),
      .b         (b_w[1]),
      .out_valid (ov32),
      .out_ready (out_ready_w[1]),
      .result    (res32),
      .cout      (cout32),
      .ofl       (ofl32)
   );

   function automatic logic get_ir(input int idx);
      return (idx == 0) ? ir16 : ir32;
   endfunction
   function automatic logic get_ov(input int idx);
      return (idx == 0) ? ov16 : ov32;
   endfunction
   function automatic logic [31:0] get_res(input int idx);
      return (idx == 0) ? {16'h0, res16} : res32;
   endfunction
   function automatic logic get_cout(input int idx);
      return (idx == 0) ? cout16 : cout32;
   endfunction
   function automatic logic get_ofl(input int idx);
      return (idx == 0) ? ofl16 : ofl32;
   endfunction

   function automatic longint sval(input longint unsigned x, input int w);
      longint unsigned half = 64'd1 << (w - 1);
      if (x >= half) return longint'(x) - longint'(64'd1 << w);
      return longint'(x);
   endfunction

   // Reference: arithmetic on wide integers, masked to the ALU width.
   function automatic exp_t ref_alu(input int w, input logic [3:0] o,
                                    input longint unsigned x, input longint unsigned y);
      exp_t e;
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned s;
      int sh = int'(y % longint'(w));
      e.r = 0; e.c = 0; e.o = 0;
      case (o)
         4'd0: begin
            s = x + y;
            e.r = s & mask; e.c = s[w];
            e.o = (sval(x, w) + sval(y, w)) != sval(e.r, w);
         end
         4'd1: begin
            s = x + (~y & mask) + 1;
            e.r = s & mask; e.c = s[w];
            e.o = (sval(x, w) - sval(y, w)) != sval(e.r, w);
         end
         4'd2:  e.r = x ^ y;
         4'd3:  e.r = x & ~y & mask;
         4'd4:  e.r = ((x << sh) | (x >> (w - sh))) & mask;
         4'd5:  e.r = (x << sh) & mask;
         4'd6:  e.r = ((x >> sh) | (x << (w - sh))) & mask;
         4'd7:  e.r = x >> sh;
         4'd8:  for (int i = 0; i < w; i++) if (x[i]) e.r = e.r | (64'd1 << (w - 1 - i));
         4'd9:  e.r = (x == y) ? 1 : 0;
         4'd10: e.r = (sval(x, w) < sval(y, w)) ? 1 : 0;
         4'd11: e.r = (sval(x, w) <= sval(y, w)) ? 1 : 0;
         4'd12: e.r = ((x + y) >> w) & 1;
         4'd13: e.r = y;
         4'd14: e.r = ((x << (w / 2)) | (y & ((64'd1 << (w / 2)) - 1))) & mask;
         default: e.r = (x * y) & mask;
      endcase
      return e;
   endfunction

   // Offer one op and return at the negedge after the accepting edge.
   task automatic issue(input int idx, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      op_w[idx] = o; a_w[idx] = x; b_w[idx] = y; in_valid_w[idx] = 1'b1;
      #1;
      while (!get_ir(idx) && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!get_ir(idx)) begin
         tests++; fails++;
         $display("FAIL issue_timeout dut=%0d op=%0d in_ready=%b required 1", idx, o, get_ir(idx));
      end
      @(negedge clk);
      in_valid_w[idx] = 1'b0;
   endtask

   task automatic test_reset();
      bit stale = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++; if (ov16 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", ov16); end
      tests++; if (res16 !== 16'h0) begin fails++; $display("FAIL reset_result got=%h exp=0000", res16); end
      tests++; if (ir16 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", ir16); end
      $display("[TB] reset: out_valid=%b result=%h in_ready=%b", ov16, res16, ir16);
      // Abandon a MUL part way through.
      issue(0, 4'd15, 32'hFFFF, 32'hFFFF);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++; if (ov16 !== 1'b0) begin fails++; $display("FAIL midmul_out_valid got=%b exp=0", ov16); end
      tests++; if (res16 !== 16'h0) begin fails++; $display("FAIL midmul_result got=%h exp=0000", res16); end
      tests++; if (ir16 !== 1'b1) begin fails++; $display("FAIL midmul_in_ready got=%b exp=1", ir16); end
      repeat (24) begin
         @(negedge clk);
         if (ov16 !== 1'b0) stale = 1;
      end
      tests++; if (stale) begin fails++; $display("FAIL midmul_stale out_valid got=1 exp=0"); end
      $display("[TB] mid-MUL reset: out_valid=%b result=%h stale=%0d", ov16, res16, stale);
   endtask

   task automatic test_vectors();
      out_ready_w[0] = 1'b1;
      foreach (vecs[i]) begin
         issue(0, vecs[i].op, {16'h0, vecs[i].a}, {16'h0, vecs[i].b});
         tests++;
         if (ov16 !== 1'b1 || res16 !== vecs[i].r || cout16 !== vecs[i].c || ofl16 !== vecs[i].o) begin
            fails++;
            $display("FAIL vec%0d op=%0d got v=%b r=%h c=%b o=%b exp v=1 r=%h c=%b o=%b",
                     i, vecs[i].op, ov16, res16, cout16, ofl16, vecs[i].r, vecs[i].c, vecs[i].o);
         end
         $display("[TB] op=%0d a=%h b=%h -> r=%h c=%b o=%b", vecs[i].op, vecs[i].a, vecs[i].b,
                  res16, cout16, ofl16);
      end
      @(negedge clk);
   endtask

   task automatic test_mul();
      int busy_bad = 0;
      int n = 0;
      out_ready_w[0] = 1'b1;
      issue(0, 4'd15, 32'h0123, 32'h0011);
      for (int k = 0; k < 16; k++) begin
         if (ir16 !== 1'b0 || ov16 !== 1'b0) busy_bad++;
         @(negedge clk);
      end
      tests++; if (busy_bad != 0) begin fails++; $display("FAIL mul_busy bad_cycles=%0d exp=0", busy_bad); end
      tests++;
      if (ov16 !== 1'b1 || res16 !== 16'h1353 || cout16 !== 1'b0 || ofl16 !== 1'b0) begin
         fails++;
         $display("FAIL mul_latency got v=%b r=%h c=%b o=%b exp v=1 r=1353 c=0 o=0", ov16, res16, cout16, ofl16);
      end
      $display("[TB] MUL 0123*0011 -> v=%b r=%h after 16 cycles", ov16, res16);
      @(negedge clk);
      issue(0, 4'd15, 32'hFFFF, 32'hFFFF);
      while (ov16 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      tests++;
      if (ov16 !== 1'b1 || res16 !== 16'h0001) begin
         fails++;
         $display("FAIL mul_ffff got v=%b r=%h exp v=1 r=0001", ov16, res16);
      end
      $display("[TB] MUL ffff*ffff -> r=%h", res16);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      out_ready_w[0] = 1'b0;
      issue(0, 4'd0, 32'h0100, 32'h0023);
      op_w[0] = 4'd2; a_w[0] = 32'hF0F0; b_w[0] = 32'h0FF0; in_valid_w[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (ov16 !== 1'b1 || res16 !== 16'h0123 || ir16 !== 1'b0) bad++;
         @(negedge clk);
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
      out_ready_w[0] = 1'b1;
      #1;
      tests++; if (ir16 !== 1'b1) begin fails++; $display("FAIL bp_passthru_ready got=%b exp=1", ir16); end
      @(negedge clk);
      in_valid_w[0] = 1'b0;
      tests++;
      if (ov16 !== 1'b1 || res16 !== 16'hFF00) begin
         fails++;
         $display("FAIL bp_handoff got v=%b r=%h exp v=1 r=ff00", ov16, res16);
      end
      @(negedge clk);
      tests++; if (ov16 !== 1'b0) begin fails++; $display("FAIL bp_duplicate out_valid got=%b exp=0", ov16); end
      $display("[TB] back-pressure hold and same-edge handoff done, bad=%0d", bad);
   endtask

   task automatic test_stream(input int idx, input int nops);
      int w = (idx == 0) ? 16 : 32;
      longint unsigned mask = (64'd1 << w) - 1;
      exp_t q[$];
      exp_t e;
      int sent = 0;
      int recvd = 0;
      bit drop = 0;
      in_valid_w[idx] = 1'b0;
      for (int cyc = 0; cyc < 40000 && recvd < nops; cyc++) begin
         @(negedge clk);
         if (drop) begin in_valid_w[idx] = 1'b0; drop = 0; end
         if (!in_valid_w[idx] && sent < nops && $urandom_range(0, 3) != 0) begin
            op_w[idx] = 4'($urandom_range(0, 15));
            a_w[idx]  = 32'($urandom & mask);
            b_w[idx]  = ($urandom_range(0, 7) == 0) ? a_w[idx] : 32'($urandom & mask);
            in_valid_w[idx] = 1'b1;
         end
         out_ready_w[idx] = ($urandom_range(0, 3) != 0);
         #1;
         if (get_ov(idx) && out_ready_w[idx]) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL stream%0d_extra got r=%h exp no result", w, get_res(idx));
            end else begin
               e = q.pop_front();
               if (get_res(idx) !== e.r[31:0] || get_cout(idx) !== e.c || get_ofl(idx) !== e.o) begin
                  fails++;
                  $display("FAIL stream%0d_result #%0d got r=%h c=%b o=%b exp r=%h c=%b o=%b", w, recvd,
                           get_res(idx), get_cout(idx), get_ofl(idx), e.r[31:0], e.c, e.o);
               end
            end
            recvd++;
         end
         if (in_valid_w[idx] && get_ir(idx)) begin
            q.push_back(ref_alu(w, op_w[idx], longint'(a_w[idx]), longint'(b_w[idx])));
            sent++;
            drop = 1;
         end
      end
      @(negedge clk);
      if (drop) in_valid_w[idx] = 1'b0;
      out_ready_w[idx] = 1'b1;
      tests++;
      if (recvd != nops || q.size() != 0) begin
         fails++;
         $display("FAIL stream%0d_count got recvd=%0d pending=%0d exp recvd=%0d pending=0", w, recvd, q.size(), nops);
      end
      $display("[TB] stream W=%0d: sent=%0d received=%0d", w, sent, recvd);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         in_valid_w[i] = 1'b0; op_w[i] = 4'd0; a_w[i] = '0; b_w[i] = '0; out_ready_w[i] = 1'b1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_vectors();
      test_mul();
      test_back_to_back();
      test_stream(0, 1000);
      test_stream(1, 1000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
